// File: rtl/mps_relay_ctrl.sv
// Relay/contactor driver: registered discharge/slow-on/main commands with
// break-before-make dead time, debounced field inputs and sticky feedback faults.
module mps_relay_ctrl #(
  parameter logic [15:0] DB_CYC   = 16'd1000,
  parameter logic [15:0] DEAD_CYC = 16'd10000,
  parameter logic [28:0] FB_TO    = 29'd300000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_on_state,
  input  logic [3:0]  i_off_state,
  input  logic        i_intl,
  input  logic [15:0] i_aux_do,
  input  logic [15:0] i_ext_di_raw,
  output logic [15:0] o_ext_do,
  output logic [15:0] o_ext_di,
  output logic [2:0]  o_mismatch,
  output logic        o_relay_intl
);

  function automatic logic dis_req_f(input logic [3:0] on_s, input logic [3:0] off_s);
    return (on_s == 4'd0) || (on_s == 4'd1) || (on_s == 4'd15) ||
           (off_s == 4'd2) || (off_s == 4'd3);
  endfunction

  function automatic logic slow_req_f(input logic [3:0] on_s);
    return (on_s >= 4'd6) && (on_s <= 4'd11);
  endfunction

  function automatic logic main_req_f(input logic [3:0] on_s, input logic [3:0] off_s);
    return (on_s >= 4'd10) && (on_s <= 4'd14) && !((off_s >= 4'd1) && (off_s <= 4'd3));
  endfunction

  logic [15:0] do_q, do_d;
  logic [15:0] main_dead_q, main_dead_d;
  logic [15:0] dis_dead_q, dis_dead_d;
  logic [15:0] sync1_q, sync2_q, di_q;
  logic [15:0] db_cnt_q [16];
  logic [28:0] fb_tmr_q [3];
  logic [2:0]  mis_q;
  logic        safe_s, dis_req_s, slow_req_s, main_req_s, dis_cmd_s, main_cmd_s;

  // Request decode, safe override and dead-time gating of the relay commands
  always_comb begin
    safe_s     = i_intl | (|mis_q);
    dis_req_s  = 1'b1;
    slow_req_s = 1'b0;
    main_req_s = 1'b0;
    if (safe_s) begin
      dis_req_s  = 1'b1;
      slow_req_s = 1'b0;
      main_req_s = 1'b0;
    end else begin
      dis_req_s  = dis_req_f(i_on_state, i_off_state);
      slow_req_s = slow_req_f(i_on_state);
      main_req_s = main_req_f(i_on_state, i_off_state);
    end
    // A saturated counter alone is not enough: the opposing relay must be low right now too.
    dis_cmd_s  = dis_req_s && (main_dead_q == DEAD_CYC) && !do_q[1];
    main_cmd_s = main_req_s && (dis_dead_q == DEAD_CYC) && !do_q[3] && !dis_cmd_s;
    do_d       = {i_aux_do[15:4], dis_cmd_s, slow_req_s, main_cmd_s, i_aux_do[0]};

    if (do_q[1]) begin
      main_dead_d = 16'd0;
    end else if (main_dead_q == DEAD_CYC) begin
      main_dead_d = DEAD_CYC;
    end else begin
      main_dead_d = main_dead_q + 16'd1;
    end

    if (do_q[3]) begin
      dis_dead_d = 16'd0;
    end else if (dis_dead_q == DEAD_CYC) begin
      dis_dead_d = DEAD_CYC;
    end else begin
      dis_dead_d = dis_dead_q + 16'd1;
    end
  end

  // Output command register and dead-time counters
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      do_q        <= 16'h0008;
      main_dead_q <= DEAD_CYC;
      dis_dead_q  <= DEAD_CYC;
    end else begin
      do_q        <= do_d;
      main_dead_q <= main_dead_d;
      dis_dead_q  <= dis_dead_d;
    end
  end

  // Two-flop synchroniser followed by a per-bit debounce counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 16'h0000;
      sync2_q <= 16'h0000;
      di_q    <= 16'h0000;
      for (int b = 0; b < 16; b++) begin
        db_cnt_q[b] <= 16'd0;
      end
    end else begin
      sync1_q <= i_ext_di_raw;
      sync2_q <= sync1_q;
      for (int b = 0; b < 16; b++) begin
        if (sync2_q[b] != di_q[b]) begin
          if (db_cnt_q[b] == (DB_CYC - 16'd1)) begin
            di_q[b]     <= sync2_q[b];
            db_cnt_q[b] <= 16'd0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 16'd1;
          end
        end else begin
          db_cnt_q[b] <= 16'd0;
        end
      end
    end
  end

  // Feedback supervision; index r covers DO/DI bit r+1 (main, slow-on, discharge)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mis_q <= 3'b000;
      for (int r = 0; r < 3; r++) begin
        fb_tmr_q[r] <= 29'd0;
      end
    end else if (i_on_state == 4'd1) begin
      mis_q <= 3'b000;
      for (int r = 0; r < 3; r++) begin
        fb_tmr_q[r] <= 29'd0;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        if (do_q[r+1] != di_q[r+1]) begin
          if (fb_tmr_q[r] == (FB_TO - 29'd1)) begin
            mis_q[r] <= 1'b1;
          end else begin
            fb_tmr_q[r] <= fb_tmr_q[r] + 29'd1;
          end
        end else begin
          fb_tmr_q[r] <= 29'd0;
        end
      end
    end
  end

  assign o_ext_do     = do_q;
  assign o_ext_di     = di_q;
  assign o_mismatch   = mis_q;
  assign o_relay_intl = |mis_q;

endmodule

// File: tb/tb_mps_relay_ctrl.sv
// Self-checking bench for mps_relay_ctrl with a history-based reference model
// (relay history window, sample window for debounce, mismatch run lengths).
module tb_mps_relay_ctrl;

  localparam int DBI   = 4;
  localparam int DEADI = 3;
  localparam int FBI   = 20;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_on_state = 4'd0;
  logic [3:0]  i_off_state = 4'd0;
  logic        i_intl = 1'b0;
  logic [15:0] i_aux_do = 16'h0000;
  logic [15:0] i_ext_di_raw = 16'h0000;
  logic [15:0] o_ext_do;
  logic [15:0] o_ext_di;
  logic [2:0]  o_mismatch;
  logic        o_relay_intl;

  int checks = 0;
  int passed = 0;

  // model state
  logic [15:0] m_do, m_di, m_s1, m_s2;
  logic [2:0]  m_mis;
  logic [15:0] hist [0:DEADI];
  logic [15:0] samp [0:DBI-1];
  int          run [0:2];
  logic        mirror = 1'b1;
  logic [15:0] raw_base = 16'h0000;
  logic [2:0]  fb_kill = 3'b000;

  mps_relay_ctrl #(.DB_CYC(16'd4), .DEAD_CYC(16'd3), .FB_TO(29'd20)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_on_state(i_on_state), .i_off_state(i_off_state),
    .i_intl(i_intl), .i_aux_do(i_aux_do), .i_ext_di_raw(i_ext_di_raw),
    .o_ext_do(o_ext_do), .o_ext_di(o_ext_di), .o_mismatch(o_mismatch),
    .o_relay_intl(o_relay_intl)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_do = 16'h0008; m_di = 16'h0000; m_s1 = 16'h0000; m_s2 = 16'h0000; m_mis = 3'b000;
    for (int k = 0; k < DEADI; k++) hist[k] = 16'h0000;
    hist[DEADI] = 16'h0008;
    for (int k = 0; k < DBI; k++) samp[k] = 16'h0000;
    for (int r = 0; r < 3; r++) run[r] = 0;
  endtask

  // One clock: predict from the rules, advance to #1 after the edge, commit.
  task automatic tick();
    logic [15:0] n_do, n_di, dmask;
    logic [15:0] n_samp [0:DBI-1];
    logic [2:0]  n_mis;
    int          n_run [0:2];
    logic        rd, rs, rm, main_low, dis_low;
    if (mirror) i_ext_di_raw = {raw_base[15:4], m_do[3:1] & ~fb_kill, raw_base[0]};
    else        i_ext_di_raw = raw_base;
    rd = (i_on_state inside {4'd0, 4'd1, 4'd15}) || (i_off_state inside {4'd2, 4'd3});
    rs = i_on_state inside {[4'd6:4'd11]};
    rm = (i_on_state inside {[4'd10:4'd14]}) && !(i_off_state inside {[4'd1:4'd3]});
    if (i_intl || (m_mis != 3'b000)) begin rd = 1'b1; rs = 1'b0; rm = 1'b0; end
    main_low = 1'b1; dis_low = 1'b1;
    for (int k = 0; k <= DEADI; k++) begin
      if (hist[k][1]) main_low = 1'b0;
      if (hist[k][3]) dis_low = 1'b0;
    end
    n_do = {i_aux_do[15:4], rd && main_low, rs, rm && dis_low, i_aux_do[0]};
    for (int k = 0; k < DBI - 1; k++) n_samp[k] = samp[k+1];
    n_samp[DBI-1] = m_s2;
    dmask = 16'hFFFF;
    for (int k = 0; k < DBI; k++) dmask = dmask & (n_samp[k] ^ m_di);
    n_di = m_di ^ dmask;
    n_mis = m_mis;
    for (int r = 0; r < 3; r++) begin
      if (m_do[r+1] != m_di[r+1]) n_run[r] = run[r] + 1;
      else n_run[r] = 0;
      if (n_run[r] >= FBI) n_mis[r] = 1'b1;
    end
    if (i_on_state == 4'd1) begin
      n_mis = 3'b000;
      for (int r = 0; r < 3; r++) n_run[r] = 0;
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < DEADI; k++) hist[k] = hist[k+1];
    hist[DEADI] = n_do;
    for (int k = 0; k < DBI; k++) samp[k] = n_samp[k];
    m_s2 = m_s1; m_s1 = i_ext_di_raw;
    m_do = n_do; m_di = n_di; m_mis = n_mis;
    for (int r = 0; r < 3; r++) run[r] = n_run[r];
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b0;
    model_reset();
    #2;
    checks++; if (o_ext_do !== 16'h0008) $display("FAIL reset_do: got %h want 0008", o_ext_do); else passed++;
    checks++; if (o_ext_di !== 16'h0000) $display("FAIL reset_di: got %h want 0000", o_ext_di); else passed++;
    checks++; if ({o_mismatch, o_relay_intl} !== 4'b0000) $display("FAIL reset_mis: got %b%b want 0000", o_mismatch, o_relay_intl); else passed++;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (o_ext_do !== 16'h0008) $display("FAIL reset_hold_dis: got %h want 0008", o_ext_do); else passed++;
    end
  endtask

  task automatic test_power_on();
    logic [3:0] steps [0:6];
    logic [2:0] exp_rel [0:6];
    steps   = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd10, 4'd12, 4'd14};
    exp_rel = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b011, 3'b001, 3'b001};
    mirror = 1'b1; fb_kill = 3'b000;
    for (int s = 0; s < 7; s++) begin
      i_on_state = steps[s];
      tick();
      checks++;
      if (o_ext_do[3:1] !== exp_rel[s])
        $display("FAIL power_on_step%0d: relays %b want %b", steps[s], o_ext_do[3:1], exp_rel[s]);
      else passed++;
      for (int n = 0; n < 11; n++) begin
        tick();
        checks++;
        if ({o_ext_do, o_ext_di, o_mismatch, o_relay_intl} !== {m_do, m_di, m_mis, |m_mis})
          $display("FAIL power_on_model: got do=%h di=%h mis=%b want do=%h di=%h mis=%b", o_ext_do, o_ext_di, o_mismatch, m_do, m_di, m_mis);
        else passed++;
      end
    end
    checks++; if (o_mismatch !== 3'b000) $display("FAIL power_on_nomis: got %b want 000", o_mismatch); else passed++;
  endtask

  task automatic test_off_seq();
    i_off_state = 4'd1;
    tick();
    checks++; if (o_ext_do[1] !== 1'b0) $display("FAIL off_main_drop: got %b want 0", o_ext_do[1]); else passed++;
    i_off_state = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (o_ext_do[3] !== (k == 4)) $display("FAIL off_dead_time edge%0d: dis %b want %b", k, o_ext_do[3], (k == 4));
      else passed++;
    end
    for (int n = 0; n < 14; n++) begin
      if (n == 6) i_off_state = 4'd3;
      if (n == 10) begin i_off_state = 4'd0; i_on_state = 4'd0; end
      tick();
      checks++;
      if ((o_ext_do[1] & o_ext_do[3]) || ({o_ext_do, o_ext_di, o_mismatch} !== {m_do, m_di, m_mis}))
        $display("FAIL off_model: got do=%h di=%h mis=%b want do=%h di=%h mis=%b", o_ext_do, o_ext_di, o_mismatch, m_do, m_di, m_mis);
      else passed++;
    end
  endtask

  task automatic test_debounce();
    raw_base[5] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) raw_base[5] = 1'b0;
      tick();
      checks++; if (o_ext_di[5] !== 1'b0) $display("FAIL debounce_glitch: di5 %b want 0", o_ext_di[5]); else passed++;
    end
    raw_base[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (o_ext_di[5] !== (k >= 6)) $display("FAIL debounce_rise edge%0d: di5 %b want %b", k, o_ext_di[5], (k >= 6));
      else passed++;
    end
    raw_base[5] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (o_ext_di !== m_di) $display("FAIL debounce_fall: got %h want %h", o_ext_di, m_di); else passed++;
    end
  endtask

  task automatic test_mismatch();
    i_on_state = 4'd4;
    repeat (10) tick();
    fb_kill = 3'b001;
    i_on_state = 4'd10;
    tick();
    checks++; if (o_ext_do[1] !== 1'b1) $display("FAIL mis_main_on: got %b want 1", o_ext_do[1]); else passed++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({o_mismatch, o_relay_intl} !== ((k == 20) ? 4'b0011 : 4'b0000))
        $display("FAIL mis_timer edge%0d: mis %b intl %b", k, o_mismatch, o_relay_intl);
      else passed++;
    end
    tick();
    checks++; if (o_ext_do[2:1] !== 2'b00) $display("FAIL mis_safe: got %b want 00", o_ext_do[2:1]); else passed++;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if ({o_ext_do, o_mismatch} !== {m_do, m_mis})
        $display("FAIL mis_model: got do=%h mis=%b want do=%h mis=%b", o_ext_do, o_mismatch, m_do, m_mis);
      else passed++;
    end
    i_on_state = 4'd1;
    tick();
    checks++; if ({o_mismatch, o_relay_intl} !== 4'b0000) $display("FAIL mis_clear: got %b%b want 0000", o_mismatch, o_relay_intl); else passed++;
    fb_kill = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_interlock();
    i_on_state = 4'd4;
    repeat (8) tick();
    i_on_state = 4'd14;
    repeat (10) tick();
    i_aux_do = 16'hA5F1;
    i_intl = 1'b1;
    tick();
    checks++;
    if ({o_ext_do[15:4], o_ext_do[2:0]} !== {12'hA5F, 3'b001})
      $display("FAIL intl_first_edge: got %h want A5F with relays 2:1 low, bit0 1", o_ext_do);
    else passed++;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if (o_ext_do[3] !== (k == 5)) $display("FAIL intl_dead edge%0d: dis %b want %b", k, o_ext_do[3], (k == 5));
      else passed++;
    end
    i_intl = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n == 5) i_aux_do = 16'h0000;
      tick();
      checks++;
      if ({o_ext_do, o_ext_di, o_mismatch} !== {m_do, m_di, m_mis})
        $display("FAIL intl_model: got do=%h di=%h mis=%b want do=%h di=%h mis=%b", o_ext_do, o_ext_di, o_mismatch, m_do, m_di, m_mis);
      else passed++;
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      i_on_state  = 4'($urandom_range(0, 15));
      i_off_state = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      i_intl      = ($urandom_range(0, 7) == 0);
      raw_base    = 16'($urandom);
      fb_kill     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      hold        = $urandom_range(1, 12);
      for (int n = 0; n < hold; n++) begin
        i_aux_do = 16'($urandom);
        tick();
        checks++;
        if ((o_ext_do[1] & o_ext_do[3]) ||
            ({o_ext_do, o_ext_di, o_mismatch, o_relay_intl} !== {m_do, m_di, m_mis, |m_mis}))
          $display("FAIL random_model: on=%0d off=%0d got do=%h di=%h mis=%b want do=%h di=%h mis=%b", i_on_state, i_off_state, o_ext_do, o_ext_di, o_mismatch, m_do, m_di, m_mis);
        else passed++;
      end
    end
    i_intl = 1'b0; fb_kill = 3'b000; raw_base = 16'h0000;
  endtask

  task automatic test_async_reset();
    i_on_state = 4'd1; i_off_state = 4'd0; i_aux_do = 16'hFFF1;
    repeat (3) tick();
    i_on_state = 4'd4;
    repeat (8) tick();
    fb_kill = 3'b001;
    i_on_state = 4'd10;
    repeat (26) tick();
    checks++;
    if ({o_ext_do, o_mismatch} !== {m_do, m_mis}) $display("FAIL areset_pre: got do=%h mis=%b want do=%h mis=%b", o_ext_do, o_mismatch, m_do, m_mis);
    else passed++;
    #2 i_rst = 1'b0;
    #1;
    checks++; if (o_ext_do !== 16'h0008) $display("FAIL areset_do: got %h want 0008", o_ext_do); else passed++;
    checks++; if ({o_mismatch, o_relay_intl} !== 4'b0000) $display("FAIL areset_mis: got %b%b want 0000", o_mismatch, o_relay_intl); else passed++;
    model_reset();
    fb_kill = 3'b000; i_aux_do = 16'h0000; i_on_state = 4'd0;
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if ({o_ext_do, o_ext_di, o_mismatch} !== {m_do, m_di, m_mis})
        $display("FAIL areset_after: got do=%h di=%h mis=%b want do=%h di=%h mis=%b", o_ext_do, o_ext_di, o_mismatch, m_do, m_di, m_mis);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_off_seq();
    test_debounce();
    test_mismatch();
    test_interlock();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mps_relay_ctrl.md
# mps_relay_ctrl

Relay/contactor driver stage downstream of the MPS operation FSM. It converts the on/off state codes into registered discharge, slow-on and main contactor commands, with break-before-make dead time between discharge and main. It synchronises and debounces the external digital inputs that the FSM polls. It raises a sticky interlock when a relay's feedback disagrees with its command for too long.

## Interface
- DB_CYC, 1000: cycles a synchronised DI bit must differ before the debounced value changes (16-bit).
- DEAD_CYC, 10000: minimum cycles main and discharge outputs must both be low between opposing commands (16-bit).
- FB_TO, 300_000_000: command/feedback mismatch cycles before a fault latches (29-bit).
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_on_state  in  4  FSM on-state code (0 IDLE, 1 CLR, 4..13 check/done steps, 14 SYSTEM_ON, 15 FAIL).
- i_off_state  in  4  FSM off-state code (0 IDLE, 1 MAIN_OFF, 2 DISCHA_ON, 3 SYSTEM_OFF).
- i_intl  in  1  external interlock; forces the safe output pattern while high.
- i_aux_do  in  16  pass-through for DO bits 0 and 15:4.
- i_ext_di_raw  in  16  asynchronous field inputs.
- o_ext_do  out  16  bit3 discharge relay, bit2 slow-on relay, bit1 main contactor, others = i_aux_do registered.
- o_ext_di  out  16  debounced inputs, consumed by the FSM (bit3 discharge, bit2 slow-on, bit1 main feedback).
- o_mismatch  out  3  sticky fault per relay ([0]=main, [1]=slow-on, [2]=discharge).
- o_relay_intl  out  1  OR of o_mismatch; feeds the FSM interlock input.

## Operation
- Requested commands are combinational from the state inputs:
  - discharge req = on_state ∈ {0,1,15} OR off_state ∈ {2,3}.
  - slow-on req = on_state ∈ 6..11.
  - main req = on_state ∈ 10..14 AND off_state ∉ {1,2,3}.
- Safe mode applies when i_intl high or any o_mismatch bit is set. In safe mode all requests are replaced by: discharge=1, slow-on=0, main=0.
- Dead time (break-before-make):
  - A main counter counts consecutive cycles with o_ext_do[1]=0, saturating at DEAD_CYC. A discharge counter counts cycles with o_ext_do[3]=0, likewise.
  - Discharge output asserts only when requested AND the main counter = DEAD_CYC.
  - Main output asserts only when requested AND the discharge counter = DEAD_CYC.
  - Deassertion of any relay is never delayed. Slow-on has no dead-time constraint.
- Main and discharge outputs are never high in the same cycle.
- DI path, per bit:
  - Two-flop synchroniser.
  - Counter increments while the synchronised bit ≠ o_ext_di bit, and resets when they are equal.
  - When the counter reaches DB_CYC-1 and the bits still differ, o_ext_di takes the new value and the counter clears.
- Mismatch, per relay:
  - A 29-bit timer increments while o_ext_do bit ≠ o_ext_di bit, and clears when they match.
  - When the timer reaches FB_TO-1, the corresponding o_mismatch bit sets and stays set.
- Clearing: all o_mismatch bits and timers clear while i_on_state == 1 (CLR). Clear has priority over setting in the same cycle.
- Mismatch in safe mode is still evaluated against the safe pattern.
- Unlisted state codes request nothing except discharge when on_state is in {0,1,15}.

## Timing
- Reset values:
  - o_ext_do = 16'h0008.
  - o_ext_di = 0, o_mismatch = 0, o_relay_intl = 0.
  - Dead-time counters preset to DEAD_CYC, so discharge holds immediately after reset.
  - DI counters and mismatch timers = 0.
- Command latency: o_ext_do updates 1 edge after a state input change, when no dead time applies. i_aux_do also has 1-edge latency.
- Dead time: discharge rises exactly DEAD_CYC+1 edges after o_ext_do[1] falls, if requested throughout. Main behaves symmetrically.
- DI latency: a raw change held stable appears on o_ext_di DB_CYC+2 edges later. A glitch shorter than DB_CYC cycles never propagates.
- Mismatch: o_mismatch sets FB_TO edges after the first mismatching cycle. o_relay_intl follows combinationally from o_mismatch. o_ext_do goes safe 1 edge later.
- i_intl assertion: main/slow-on drop 1 edge later. Discharge then follows the dead-time rule.
- Reset mid-operation returns all outputs to reset values asynchronously.

## Test plan
Parameters for all tests: DB_CYC=4, DEAD_CYC=3, FB_TO=20.
- Power-on sequence: step on_state 0→1→4→6→10→12→14, DI feedback mirroring DO via the bench → o_ext_do[3] drops 1 edge after on_state=4; bit2 high for 6..11; bit1 high from 10 onward; no o_mismatch.
- Off sequence from 14: off_state 1 → bit1 low next edge; off_state 2 → bit3 high exactly 4 edges after bit1 fell; bit1 and bit3 never simultaneously 1.
- Debounce: raw DI bit5 pulse of 3 cycles → o_ext_di[5] stays 0; pulse of 10 cycles → o_ext_di[5]=1 exactly 6 edges after the raw rise.
- Mismatch: on_state=10, main feedback held 0 → o_mismatch[0]=1 at edge 20, o_relay_intl=1, o_ext_do[2:1]=0; later on_state=1 → o_mismatch=0.
- Interlock: i_intl pulsed while at 14 → bits 2:1 low next edge, bit3 high after dead time; i_aux_do=16'hA5F1 → o_ext_do[15:4,0] = A5F pattern and bit0=1, 1 edge later.
- Async reset asserted mid-sequence → o_ext_do=16'h0008 and o_mismatch=0 with no clock edge.
